// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared constants and width helper for the priority encoder pipe
package encoder_pkg;

  localparam int DEF_N     = 8;
  localparam int DEF_CNT_W = 8;

  // LSB_PRI encoding
  localparam int LSB_FIRST = 1;
  localparam int MSB_FIRST = 0;

  // Index width for an n-bit request vector; a 1-bit index is the floor.
  function automatic int enc_width(input int n);
    int w;
    w = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/priority_encoder_comb.sv
// rtl/priority_encoder_comb.sv - combinational find-first / find-last encoder
// multi is only computed when PRIORITY_ENCODER_MULTI_DETECT_EN is defined, else tied to 0.
module priority_encoder_comb
  import encoder_pkg::*;
#(
  parameter  int N       = DEF_N,
  parameter  int LSB_PRI = LSB_FIRST,
  localparam int W       = enc_width(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         hit,
  output logic         multi
);

  // The scan order makes the last matching assignment the winner.
  always_comb begin
    idx = '0;
    if (LSB_PRI == LSB_FIRST) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) idx = W'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) idx = W'(i);
      end
    end
  end

  assign hit = |req;

`ifdef PRIORITY_ENCODER_MULTI_DETECT_EN
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(req & (req - N'(1)));
`else
  assign multi = 1'b0;
`endif

endmodule

// File: rtl/priority_encoder_pipe.sv
// rtl/priority_encoder_pipe.sv - registered N-to-log2(N) priority encoder with valid/ready handshakes
// Multi-hot flag and counter exist only when PRIORITY_ENCODER_MULTI_DETECT_EN is defined.
module priority_encoder_pipe
  import encoder_pkg::*;
#(
  parameter  int N       = DEF_N,
  parameter  int LSB_PRI = LSB_FIRST,
  parameter  int CNT_W   = DEF_CNT_W,
  localparam int W       = enc_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_idx,
  output logic             out_hit,
  output logic             out_multi,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  logic [W-1:0] c_idx;
  logic         c_hit;
  logic         c_multi;
  logic         accept;

  priority_encoder_comb #(
    .N       (N),
    .LSB_PRI (LSB_PRI)
  ) u_comb (
    .req   (in_data),
    .idx   (c_idx),
    .hit   (c_hit),
    .multi (c_multi)
  );

  // The output register frees up in the same cycle it is consumed.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_hit   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_idx   <= c_idx;
      out_hit   <= c_hit;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef PRIORITY_ENCODER_MULTI_DETECT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_multi <= 1'b0;
    end else if (accept) begin
      out_multi <= c_multi;
    end
  end

  // Clear wins over the old value but not over a concurrent counted accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (err_clr) begin
      cnt_q <= (accept && c_multi) ? CNT_W'(1) : '0;
    end else if (accept && c_multi && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign err_cnt = cnt_q;
`else
  logic unused_multi_detect;

  assign unused_multi_detect = err_clr ^ c_multi;
  assign out_multi           = 1'b0;
  assign err_cnt             = '0;
`endif

endmodule
